// File: rtl/rs_berlekamp_sched.sv
// rtl/rs_berlekamp_sched.sv - round-robin scheduler sharing one Berlekamp engine among syndrome requesters
// Optional engine watchdog: define RS_BERLEKAMP_SCHED_WDOG_EN.
module rs_berlekamp_sched #(
    parameter int check = 30,
    parameter int m     = 8,
    parameter int NREQ  = 4,
    parameter int PTR_W = 1
) (
    input  logic                      iclk,
    input  logic                      ireset,
    input  logic                      iclkena,
    input  logic [NREQ-1:0]           ireq_val,
    input  logic [NREQ*PTR_W-1:0]     ireq_ptr,
    input  logic [NREQ*check*m-1:0]   ireq_syndrome,
    output logic [NREQ-1:0]           oreq_ack,
    output logic                      oeng_syndrome_val,
    output logic [PTR_W-1:0]          oeng_syndrome_ptr,
    output logic [check*m-1:0]        oeng_syndrome,
    input  logic                      ieng_done,
    output logic                      oresp_val,
    output logic [$clog2(NREQ)-1:0]   oresp_id,
    output logic                      owdog_err
);

    localparam int ID_W   = $clog2(NREQ);
    localparam int SYN_W  = check * m;
    localparam int WCNT_W = $clog2(3 * check + 8);
    localparam logic [WCNT_W-1:0] WCNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, DONE} state_t;

    state_t            state;
    logic [ID_W-1:0]   last_id;
    logic [ID_W-1:0]   own_id;
    logic [ID_W-1:0]   win_id;
    logic [WCNT_W-1:0] wcnt;
    logic              wdog_hit;

    // Scan from the farthest offset down so the nearest requester after last wins.
    function automatic logic [ID_W-1:0] rr_pick(input logic [NREQ-1:0] req,
                                                input logic [ID_W-1:0] last);
        logic [ID_W-1:0] pick;
        logic [ID_W-1:0] cand;
        pick = last;
        for (int i = NREQ; i >= 1; i--) begin
            cand = ID_W'((int'(last) + i) % NREQ);
            if (req[cand])
                pick = cand;
        end
        return pick;
    endfunction

    always_comb win_id = rr_pick(ireq_val, last_id);

`ifdef RS_BERLEKAMP_SCHED_WDOG_EN
    localparam logic [WCNT_W-1:0] WDOG_LIM = WCNT_W'(3 * check + 4);

    assign wdog_hit = (state == BUSY) && !ieng_done && (wcnt >= WDOG_LIM);

    always_ff @(posedge iclk) begin
        if (ireset)
            owdog_err <= 1'b0;
        else if (iclkena && wdog_hit)
            owdog_err <= 1'b1;
    end
`else
    assign wdog_hit  = 1'b0;
    assign owdog_err = 1'b0;
`endif

    always_ff @(posedge iclk) begin
        if (ireset) begin
            state             <= IDLE;
            last_id           <= ID_W'(NREQ - 1);
            own_id            <= '0;
            wcnt              <= '0;
            oreq_ack          <= '0;
            oeng_syndrome_val <= 1'b0;
            oeng_syndrome     <= '0;
            oeng_syndrome_ptr <= '0;
            oresp_val         <= 1'b0;
            oresp_id          <= '0;
        end else if (iclkena) begin
            oreq_ack          <= '0;
            oeng_syndrome_val <= 1'b0;
            oresp_val         <= 1'b0;
            case (state)
                IDLE: begin
                    if (|ireq_val) begin
                        own_id            <= win_id;
                        oeng_syndrome_ptr <= ireq_ptr[win_id*PTR_W +: PTR_W];
                        oeng_syndrome     <= ireq_syndrome[win_id*SYN_W +: SYN_W];
                        oreq_ack          <= NREQ'(1) << win_id;
                        oeng_syndrome_val <= 1'b1;
                        state             <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    wcnt    <= '0;
                    last_id <= own_id;
                    state   <= BUSY;
                end
                BUSY: begin
                    if (ieng_done || wdog_hit) begin
                        oresp_val <= 1'b1;
                        oresp_id  <= own_id;
                        state     <= DONE;
                    end else if (wcnt != WCNT_MAX) begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rs_berlekamp_sched.sv
// tb/tb_rs_berlekamp_sched.sv - randomized self-checking bench for rs_berlekamp_sched
module tb_rs_berlekamp_sched;

    localparam int CHECK   = 30;
    localparam int M       = 8;
    localparam int NREQ    = 4;
    localparam int PTR_W   = 1;
    localparam int ID_W    = 2;
    localparam int SYN_W   = CHECK * M;
    localparam int NOM_LAT = 3 * CHECK + 1;
    localparam int GAP     = 3 * CHECK + 4;

    logic                    iclk = 1'b0;
    logic                    ireset = 1'b1;
    logic                    iclkena = 1'b1;
    logic [NREQ-1:0]         ireq_val = '0;
    logic [NREQ*PTR_W-1:0]   ireq_ptr;
    logic [NREQ*SYN_W-1:0]   ireq_syndrome;
    logic [NREQ-1:0]         oreq_ack;
    logic                    oeng_syndrome_val;
    logic [PTR_W-1:0]        oeng_syndrome_ptr;
    logic [SYN_W-1:0]        oeng_syndrome;
    logic                    ieng_done = 1'b0;
    logic                    oresp_val;
    logic [ID_W-1:0]         oresp_id;
    logic                    owdog_err;

    logic [PTR_W-1:0] ptr_d [NREQ];
    logic [SYN_W-1:0] syn_d [NREQ];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int model_last;

    always #5 iclk = ~iclk;
    always @(posedge iclk) cyc++;

    always_comb begin
        ireq_ptr      = '0;
        ireq_syndrome = '0;
        for (int i = 0; i < NREQ; i++) begin
            ireq_ptr[i*PTR_W +: PTR_W]      = ptr_d[i];
            ireq_syndrome[i*SYN_W +: SYN_W] = syn_d[i];
        end
    end

    rs_berlekamp_sched #(.check(CHECK), .m(M), .NREQ(NREQ), .PTR_W(PTR_W)) dut (
        .iclk(iclk), .ireset(ireset), .iclkena(iclkena),
        .ireq_val(ireq_val), .ireq_ptr(ireq_ptr), .ireq_syndrome(ireq_syndrome),
        .oreq_ack(oreq_ack), .oeng_syndrome_val(oeng_syndrome_val),
        .oeng_syndrome_ptr(oeng_syndrome_ptr), .oeng_syndrome(oeng_syndrome),
        .ieng_done(ieng_done), .oresp_val(oresp_val), .oresp_id(oresp_id),
        .owdog_err(owdog_err)
    );

    function automatic logic [SYN_W-1:0] rand_syn();
        logic [SYN_W-1:0] r;
        for (int i = 0; i < SYN_W; i++) r[i] = 1'($urandom_range(0, 1));
        return r;
    endfunction

    // Requesters listed in rotation order starting just after the last grant; first active one wins.
    function automatic int model_pick(input logic [NREQ-1:0] mask);
        int order [$];
        for (int k = 1; k <= NREQ; k++) order.push_back((model_last + k) % NREQ);
        foreach (order[i]) if (mask[order[i]]) return order[i];
        return -1;
    endfunction

    task automatic wait_launch(output int waited, output bit ok);
        waited = 0;
        ok = 1'b0;
        while (waited < 300 && !ok) begin
            @(negedge iclk);
            waited++;
            if (oeng_syndrome_val === 1'b1) ok = 1'b1;
        end
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL launch_timeout: no start pulse within %0d cycles", waited); end
    endtask

    task automatic do_job(input string tag, input int lat, input bit drop,
                          output int launch_cyc, output int waited);
        int exp, bad;
        bit ok;
        logic [NREQ-1:0]  eack;
        logic [SYN_W-1:0] esyn;
        logic [PTR_W-1:0] eptr;
        exp  = model_pick(ireq_val);
        eack = '0;
        eack[exp] = 1'b1;
        esyn = syn_d[exp];
        eptr = ptr_d[exp];
        wait_launch(waited, ok);
        launch_cyc = cyc;
        if (!ok) return;
        n_tests++;
        if (oreq_ack !== eack) begin n_fail++; $display("FAIL %s ack: got %b expected %b", tag, oreq_ack, eack); end
        n_tests++;
        if (oeng_syndrome !== esyn || oeng_syndrome_ptr !== eptr) begin
            n_fail++; $display("FAIL %s eng_data: got ptr %h syn %h expected ptr %h syn %h", tag, oeng_syndrome_ptr, oeng_syndrome[31:0], eptr, esyn[31:0]);
        end
        model_last = exp;
        if (drop) ireq_val[exp] = 1'b0;
        syn_d[exp] = rand_syn();
        ptr_d[exp] = PTR_W'($urandom);
        bad = 0;
        for (int k = 1; k <= lat; k++) begin
            @(negedge iclk);
            if (oeng_syndrome_val !== 1'b0 || oreq_ack !== '0 || oresp_val !== 1'b0 ||
                oeng_syndrome !== esyn || oeng_syndrome_ptr !== eptr) bad++;
            if (k == lat) ieng_done = 1'b1;
        end
        n_tests++;
        if (bad !== 0) begin n_fail++; $display("FAIL %s busy_quiet: %0d bad cycles, expected 0", tag, bad); end
        @(negedge iclk);
        ieng_done = 1'b0;
        n_tests++;
        if (oresp_val !== 1'b1 || oresp_id !== ID_W'(exp)) begin
            n_fail++; $display("FAIL %s resp: got val %b id %0d expected val 1 id %0d", tag, oresp_val, oresp_id, exp);
        end
        @(negedge iclk);
        n_tests++;
        if (oresp_val !== 1'b0) begin n_fail++; $display("FAIL %s resp_pulse: got val %b expected 0", tag, oresp_val); end
    endtask

    task automatic test_reset();
        ireset = 1'b1;
        iclkena = 1'b1;
        ireq_val = '0;
        ieng_done = 1'b0;
        repeat (3) @(negedge iclk);
        n_tests++;
        if ({oreq_ack, oeng_syndrome_val, oresp_val, owdog_err} !== '0) begin
            n_fail++; $display("FAIL reset_flags: got ack %b val %b resp %b wdog %b expected all 0", oreq_ack, oeng_syndrome_val, oresp_val, owdog_err);
        end
        n_tests++;
        if (oeng_syndrome !== '0 || oeng_syndrome_ptr !== '0) begin n_fail++; $display("FAIL reset_eng_data: got nonzero, expected 0"); end
        n_tests++;
        if (oresp_id !== '0) begin n_fail++; $display("FAIL reset_resp_id: got %0d expected 0", oresp_id); end
        ireset = 1'b0;
        model_last = NREQ - 1;
        @(negedge iclk);
        n_tests++;
        if (oeng_syndrome_val !== 1'b0 || oresp_val !== 1'b0) begin n_fail++; $display("FAIL reset_idle: got val %b resp %b expected 0 0", oeng_syndrome_val, oresp_val); end
    endtask

    task automatic test_single();
        int lc, w;
        ireq_val = 4'b0100;
        do_job("single", NOM_LAT, 1'b1, lc, w);
    endtask

    task automatic test_back_to_back();
        int lc1, lc2, w;
        ireq_val = 4'b0010;
        do_job("b2b_a", 5, 1'b0, lc1, w);
        do_job("b2b_b", 5, 1'b1, lc2, w);
        n_tests++;
        if (lc2 - lc1 !== 8) begin n_fail++; $display("FAIL b2b_gap: got %0d expected 8", lc2 - lc1); end
    endtask

    task automatic test_rotation();
        int lc, prev, w;
        ireset = 1'b1;
        ireq_val = '1;
        @(negedge iclk);
        ireset = 1'b0;
        model_last = NREQ - 1;
        for (int j = 0; j < 5; j++) begin
            do_job("rotation", NOM_LAT, 1'b0, lc, w);
            n_tests++;
            if (model_last !== j % NREQ) begin n_fail++; $display("FAIL rotation_order: grant %0d went to %0d expected %0d", j, model_last, j % NREQ); end
            if (j > 0) begin
                n_tests++;
                if (lc - prev !== GAP) begin n_fail++; $display("FAIL rotation_gap: got %0d expected %0d", lc - prev, GAP); end
            end
            prev = lc;
        end
        ireq_val = '0;
    endtask

    task automatic test_clkena();
        int exp, w, bad;
        bit ok;
        logic [NREQ+PTR_W+SYN_W+ID_W+2:0] snap;
        ireq_val = 4'b0001;
        exp = model_pick(ireq_val);
        wait_launch(w, ok);
        model_last = exp;
        ireq_val = '0;
        repeat (20) @(negedge iclk);
        iclkena = 1'b0;
        snap = {oreq_ack, oeng_syndrome_val, oeng_syndrome_ptr, oeng_syndrome, oresp_val, oresp_id, owdog_err};
        bad = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge iclk);
            ieng_done = (k == 4);
            if ({oreq_ack, oeng_syndrome_val, oeng_syndrome_ptr, oeng_syndrome, oresp_val, oresp_id, owdog_err} !== snap) bad++;
        end
        iclkena = 1'b1;
        n_tests++;
        if (bad !== 0) begin n_fail++; $display("FAIL clkena_freeze: %0d changed cycles, expected 0", bad); end
        bad = 0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge iclk);
            if (oresp_val !== 1'b0) bad++;
            if (k == 5) ieng_done = 1'b1;
        end
        @(negedge iclk);
        ieng_done = 1'b0;
        n_tests++;
        if (bad !== 0 || oresp_val !== 1'b1 || oresp_id !== ID_W'(exp)) begin
            n_fail++; $display("FAIL clkena_resume: early %0d resp %b id %0d expected 0 1 %0d", bad, oresp_val, oresp_id, exp);
        end
        @(negedge iclk);
    endtask

    task automatic test_watchdog();
        int exp, w, bad, lc;
        bit ok;
        ireq_val = 4'b1000;
        exp = model_pick(ireq_val);
        wait_launch(w, ok);
        model_last = exp;
        ireq_val = '0;
`ifdef RS_BERLEKAMP_SCHED_WDOG_EN
        bad = 0;
        for (int k = 1; k <= 95; k++) begin
            @(negedge iclk);
            if (oresp_val !== 1'b0 || owdog_err !== 1'b0) bad++;
        end
        n_tests++;
        if (bad !== 0) begin n_fail++; $display("FAIL wdog_early: %0d early cycles, expected 0", bad); end
        @(negedge iclk);
        n_tests++;
        if (oresp_val !== 1'b1 || oresp_id !== ID_W'(exp) || owdog_err !== 1'b1) begin
            n_fail++; $display("FAIL wdog_fire: got resp %b id %0d err %b expected 1 %0d 1", oresp_val, oresp_id, owdog_err, exp);
        end
        @(negedge iclk);
        ireq_val = 4'b0010;
        do_job("wdog_next", 10, 1'b1, lc, w);
        n_tests++;
        if (owdog_err !== 1'b1) begin n_fail++; $display("FAIL wdog_sticky: got %b expected 1", owdog_err); end
`else
        bad = 0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge iclk);
            if (oresp_val !== 1'b0 || owdog_err !== 1'b0) bad++;
        end
        n_tests++;
        if (bad !== 0) begin n_fail++; $display("FAIL nowdog_wait: %0d bad cycles, expected 0", bad); end
        ieng_done = 1'b1;
        @(negedge iclk);
        ieng_done = 1'b0;
        n_tests++;
        if (oresp_val !== 1'b1 || oresp_id !== ID_W'(exp)) begin
            n_fail++; $display("FAIL nowdog_resp: got %b id %0d expected 1 %0d", oresp_val, oresp_id, exp);
        end
        @(negedge iclk);
        lc = 0;
`endif
    endtask

    task automatic test_reset_busy();
        int w, bad;
        bit ok;
        ireq_val = 4'b0100;
        wait_launch(w, ok);
        ireq_val = '0;
        repeat (41) @(negedge iclk);
        ireset = 1'b1;
        @(negedge iclk);
        ireset = 1'b0;
        ieng_done = 1'b1;
        model_last = NREQ - 1;
        n_tests++;
        if ({oreq_ack, oeng_syndrome_val, oeng_syndrome_ptr, oeng_syndrome, oresp_val, oresp_id, owdog_err} !== '0) begin
            n_fail++; $display("FAIL reset_busy_outputs: got ack %b val %b resp %b id %0d err %b expected all 0", oreq_ack, oeng_syndrome_val, oresp_val, oresp_id, owdog_err);
        end
        bad = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge iclk);
            ieng_done = 1'b0;
            if (oresp_val !== 1'b0 || oeng_syndrome_val !== 1'b0) bad++;
        end
        n_tests++;
        if (bad !== 0) begin n_fail++; $display("FAIL reset_busy_stray: %0d bad cycles, expected 0", bad); end
    endtask

    task automatic test_idle_done();
        int bad, lc, w;
        @(negedge iclk);
        ieng_done = 1'b1;
        bad = 0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge iclk);
            ieng_done = 1'b0;
            if (oresp_val !== 1'b0 || oeng_syndrome_val !== 1'b0) bad++;
        end
        n_tests++;
        if (bad !== 0) begin n_fail++; $display("FAIL idle_done_ignored: %0d bad cycles, expected 0", bad); end
        ireq_val = 4'b0010;
        do_job("idle_after", 4, 1'b1, lc, w);
        n_tests++;
        if (w !== 1) begin n_fail++; $display("FAIL idle_start_latency: got %0d expected 1", w); end
    endtask

    task automatic test_random();
        logic [NREQ-1:0] pend;
        int lc, w;
        for (int n = 0; n < 25; n++) begin
            pend = ireq_val | NREQ'($urandom);
            if ($urandom_range(0, 3) == 0) pend[$urandom_range(0, NREQ - 1)] = 1'b0;
            if (pend == '0) pend[$urandom_range(0, NREQ - 1)] = 1'b1;
            for (int i = 0; i < NREQ; i++) begin
                syn_d[i] = rand_syn();
                ptr_d[i] = PTR_W'($urandom);
            end
            ireq_val = pend;
            do_job("random", $urandom_range(1, 12), 1'b1, lc, w);
        end
        ireq_val = '0;
        repeat (3) @(negedge iclk);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            syn_d[i] = rand_syn();
            ptr_d[i] = PTR_W'($urandom);
        end
        model_last = NREQ - 1;
        test_reset();
        test_single();
        test_back_to_back();
        test_rotation();
        test_clkena();
        test_watchdog();
        test_reset_busy();
        test_idle_done();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
